// File: rtl/ctrl_pipe_if.sv
// Purpose: ID inputs and EX/MEM/WB control bundles exchanged with ctrl_pipe.
// Latency: none; this is wiring only.
// Backpressure: hazard is the only stall signal and flows back to the fetch side.
interface ctrl_pipe_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  logic               idValid;
  logic [31:0]        idInstr;
  logic               exFlush;
  logic               hazard;
  logic               exValid;
  logic [ALUOP_W-1:0] exAluOp;
  logic               exAluS1;
  logic               exAluS2;
  logic [2:0]         exBranchCtrl;
  logic               exDoBranch;
  logic               exDoJump;
  logic               exIllegal;
  logic               memValid;
  logic               memWR;
  logic [2:0]         memCtrl;
  logic               wbValid;
  logic               wbRegWR;
  logic [1:0]         wbCtrl;
  logic [4:0]         wbRd;
  logic [CNT_W-1:0]   retireCnt;

  modport master (
    output idValid, idInstr, exFlush,
    input  hazard, exValid, exAluOp, exAluS1, exAluS2, exBranchCtrl, exDoBranch,
           exDoJump, exIllegal, memValid, memWR, memCtrl, wbValid, wbRegWR,
           wbCtrl, wbRd, retireCnt
  );

  modport slave (
    input  idValid, idInstr, exFlush,
    output hazard, exValid, exAluOp, exAluS1, exAluS2, exBranchCtrl, exDoBranch,
           exDoJump, exIllegal, memValid, memWR, memCtrl, wbValid, wbRegWR,
           wbCtrl, wbRd, retireCnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Purpose: RV32I(+M) control decode in ID with an EX/MEM/WB control pipeline and retire counter.
// Latency: ID->EX 1 cycle, ->MEM 2 cycles, ->WB 3 cycles.
// Backpressure: load-use hazard stalls ID only (bubble into EX); later stages never stall.
module ctrl_pipe #(
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 32
) (
  input logic      clk,
  input logic      rst_n,
  ctrl_pipe_if.slave bus
);
  localparam int ALUOP_W = (ENABLE_M != 0) ? 5 : 4;

  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] aluop;
    logic               alus1;
    logic               alus2;
    logic [2:0]         bctl;
    logic               dobr;
    logic               dojmp;
    logic               ill;
    logic               memwr;
    logic [2:0]         memctl;
    logic               regwr;
    logic [1:0]         wbctl;
    logic [4:0]         rd;
    logic               isload;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic       memwr;
    logic [2:0] memctl;
    logic       regwr;
    logic [1:0] wbctl;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       valid;
    logic       regwr;
    logic [1:0] wbctl;
    logic [4:0] rd;
  } wb_t;

  ex_t  dec, ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic uses_rs1, uses_rs2, illegal;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = bus.idInstr[6:0];
  assign rd     = bus.idInstr[11:7];
  assign f3     = bus.idInstr[14:12];
  assign rs1    = bus.idInstr[19:15];
  assign rs2    = bus.idInstr[24:20];
  assign f7     = bus.idInstr[31:25];

  // f3 -> base ALU op; alt (f7[5]) picks SRA, and SUB only where the format allows it
  function automatic logic [4:0] alu_base(input logic [2:0] fn3, input logic alt, input logic sub_ok);
    case (fn3)
      3'd0:    alu_base = (alt && sub_ok) ? 5'd1 : 5'd0;
      3'd1:    alu_base = 5'd2;
      3'd2:    alu_base = 5'd3;
      3'd3:    alu_base = 5'd4;
      3'd4:    alu_base = 5'd5;
      3'd5:    alu_base = alt ? 5'd7 : 5'd6;
      3'd6:    alu_base = 5'd8;
      default: alu_base = 5'd9;
    endcase
  endfunction

  // ID-stage decode of the instruction word into the control bundle
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      7'b0110011: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec.regwr = 1'b1;
        dec.aluop = ALUOP_W'(alu_base(f3, f7[5], 1'b1));
        if (f7 == 7'b0000001) begin
          if (ENABLE_M != 0) dec.aluop = ALUOP_W'({2'b10, f3});
          else               illegal   = 1'b1;
        end
      end
      7'b0010011: begin
        uses_rs1  = 1'b1;
        dec.alus2 = 1'b1;
        dec.regwr = 1'b1;
        dec.aluop = ALUOP_W'(alu_base(f3, f7[5], 1'b0));
      end
      7'b0000011: begin
        uses_rs1   = 1'b1;
        dec.alus2  = 1'b1;
        dec.regwr  = 1'b1;
        dec.wbctl  = 2'd1;
        dec.memctl = f3;
        dec.isload = 1'b1;
      end
      7'b0100011: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec.alus2  = 1'b1;
        dec.memwr  = 1'b1;
        dec.memctl = f3;
      end
      7'b1100011: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec.aluop = ALUOP_W'(1);
        dec.dobr  = 1'b1;
        dec.bctl  = f3;
      end
      7'b0110111: begin
        dec.aluop = ALUOP_W'(10);
        dec.alus2 = 1'b1;
        dec.regwr = 1'b1;
      end
      7'b0010111: begin
        dec.alus1 = 1'b1;
        dec.alus2 = 1'b1;
        dec.regwr = 1'b1;
      end
      7'b1101111: begin
        dec.alus1 = 1'b1;
        dec.alus2 = 1'b1;
        dec.dojmp = 1'b1;
        dec.regwr = 1'b1;
        dec.wbctl = 2'd2;
      end
      7'b1100111: begin
        uses_rs1  = 1'b1;
        dec.alus2 = 1'b1;
        dec.dojmp = 1'b1;
        dec.regwr = 1'b1;
        dec.wbctl = 2'd2;
      end
      default: illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
    dec.rd    = rd;
    if (rd == 5'd0) dec.regwr = 1'b0;
  end

  // load-use stall: a load in EX whose destination feeds a source read in ID
  assign bus.hazard = bus.idValid & ex_q.valid & ex_q.isload & (ex_q.rd != 5'd0) &
                      ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));

  // EX next state: flush beats hazard; an illegal op becomes a bubble carrying only the illegal flag
  always_comb begin
    ex_d = '0;
    if (!(bus.exFlush || bus.hazard || !bus.idValid)) begin
      if (illegal) ex_d.ill = 1'b1;
      else         ex_d     = dec;
    end
  end

  // MEM next state is a straight slice of the EX bundle
  always_comb begin
    mem_d        = '0;
    mem_d.valid  = ex_q.valid;
    mem_d.memwr  = ex_q.memwr;
    mem_d.memctl = ex_q.memctl;
    mem_d.regwr  = ex_q.regwr;
    mem_d.wbctl  = ex_q.wbctl;
    mem_d.rd     = ex_q.rd;
  end

  // stage registers and retire counter; EX->MEM->WB never stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= {mem_q.valid, mem_q.regwr, mem_q.wbctl, mem_q.rd};
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, wb_q.valid};
    end
  end

  assign bus.exValid      = ex_q.valid;
  assign bus.exAluOp      = ex_q.aluop;
  assign bus.exAluS1      = ex_q.alus1;
  assign bus.exAluS2      = ex_q.alus2;
  assign bus.exBranchCtrl = ex_q.bctl;
  assign bus.exDoBranch   = ex_q.dobr;
  assign bus.exDoJump     = ex_q.dojmp;
  assign bus.exIllegal    = ex_q.ill;
  assign bus.memValid     = mem_q.valid;
  assign bus.memWR        = mem_q.memwr;
  assign bus.memCtrl      = mem_q.memctl;
  assign bus.wbValid      = wb_q.valid;
  assign bus.wbRegWR      = wb_q.regwr;
  assign bus.wbCtrl       = wb_q.wbctl;
  assign bus.wbRd         = wb_q.rd;
  assign bus.retireCnt    = cnt_q;
endmodule
